// File: rtl/gpio_port.sv
// Wishbone-style GPIO port: latched outputs with direction control, atomic set/clear,
// synchronised inputs and per-bit edge capture feeding a level interrupt.
module gpio_port #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [2:0]       adr_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [3:0]       sel_i,
  input  logic [31:0]      dat_i,
  output logic [31:0]      dat_o,
  output logic             ack_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe_o,
  output logic             irq_o
);

  typedef enum logic [2:0] {
    REG_OUT     = 3'd0,
    REG_IN      = 3'd1,
    REG_DIR     = 3'd2,
    REG_SET     = 3'd3,
    REG_CLR     = 3'd4,
    REG_RISE_EN = 3'd5,
    REG_FALL_EN = 3'd6,
    REG_STAT    = 3'd7
  } reg_addr_e;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [31:0]      dat_q, dat_d;
  logic             ack_q, ack_d;
  logic             irq_q, irq_d;

  logic             accept;
  logic             wr;
  logic [31:0]      byte_mask;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [31:0]      rdata;

  // No back-to-back accepts: the cycle showing ack_o never starts a new transfer.
  assign accept    = stb_i && !ack_q;
  assign wr        = accept && we_i;
  assign byte_mask = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
  assign wmask     = byte_mask[WIDTH-1:0];
  assign wdata     = dat_i[WIDTH-1:0] & wmask;
  assign sync      = sync_q[SYNC_STAGES-1];
  assign rise      = sync & ~prev_q;
  assign fall      = ~sync & prev_q;

  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;
    sync_d    = {sync_q[SYNC_STAGES-2:0], gpio_i};
    prev_d    = sync;

    if (wr) begin
      case (reg_addr_e'(adr_i))
        REG_OUT:     out_d     = (out_q & ~wmask) | wdata;
        REG_DIR:     dir_d     = (dir_q & ~wmask) | wdata;
        REG_SET:     out_d     = out_q | wdata;
        REG_CLR:     out_d     = out_q & ~wdata;
        REG_RISE_EN: rise_en_d = (rise_en_q & ~wmask) | wdata;
        REG_FALL_EN: fall_en_d = (fall_en_q & ~wmask) | wdata;
        REG_STAT:    w1c       = wdata;
        default:     ;
      endcase
    end

    // A fresh edge overrides a simultaneous write-1-to-clear of the same bit.
    stat_d = (stat_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
    irq_d  = |stat_d;

    rdata = '0;
    case (reg_addr_e'(adr_i))
      REG_OUT:     rdata[WIDTH-1:0] = out_q;
      REG_IN:      rdata[WIDTH-1:0] = sync;
      REG_DIR:     rdata[WIDTH-1:0] = dir_q;
      REG_RISE_EN: rdata[WIDTH-1:0] = rise_en_q;
      REG_FALL_EN: rdata[WIDTH-1:0] = fall_en_q;
      REG_STAT:    rdata[WIDTH-1:0] = stat_q;
      default:     ;
    endcase

    ack_d = accept;
    dat_d = accept ? rdata : dat_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      prev_q    <= '0;
      sync_q    <= '0;
      dat_q     <= '0;
      ack_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      stat_q    <= stat_d;
      prev_q    <= prev_d;
      sync_q    <= sync_d;
      dat_q     <= dat_d;
      ack_q     <= ack_d;
      irq_q     <= irq_d;
    end
  end

  assign dat_o     = dat_q;
  assign ack_o     = ack_q;
  assign gpio_o    = out_q;
  assign gpio_oe_o = dir_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_gpio_port.sv
// Self-checking bench for gpio_port: a 32-bit and an 8-bit instance share one bus and
// pin stimulus, checked from a directed vector table plus hand-written timing sequences.
module tb_gpio_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  adr;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] dat;
  logic [31:0] gpio_in;

  logic [31:0] dat32, dat8;
  logic        ack32, ack8;
  logic [31:0] out32, oe32;
  logic [7:0]  out8, oe8;
  logic        irq32, irq8;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp_rd32;
    logic [31:0] exp_rd8;
    logic [31:0] exp_out32;
    logic [7:0]  exp_out8;
    logic [31:0] exp_oe32;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  gpio_port #(.WIDTH(32), .SYNC_STAGES(2)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .adr_i(adr), .stb_i(stb), .we_i(we), .sel_i(sel),
    .dat_i(dat), .dat_o(dat32), .ack_o(ack32), .gpio_i(gpio_in), .gpio_o(out32),
    .gpio_oe_o(oe32), .irq_o(irq32)
  );

  gpio_port #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .adr_i(adr), .stb_i(stb), .we_i(we), .sel_i(sel),
    .dat_i(dat), .dat_o(dat8), .ack_o(ack8), .gpio_i(gpio_in[7:0]), .gpio_o(out8),
    .gpio_oe_o(oe8), .irq_o(irq8)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One full bus transfer; inputs change #1 after an edge, so the accept is the next edge.
  task automatic applyStimulus(input logic [2:0] a, input logic w, input logic [3:0] s,
                               input logic [31:0] d, output logic [31:0] r32,
                               output logic [31:0] r8);
    int n;
    adr = a; we = w; sel = s; dat = d; stb = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack32 && n < 4);
    checkOutput("ack32", {31'b0, ack32}, 32'd1);
    checkOutput("ack8", {31'b0, ack8}, 32'd1);
    r32 = dat32;
    r8  = dat8;
    stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    checkOutput("ack_drop", {31'b0, ack32}, 32'd0);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rd32, rd8;
    logic [3:0]  ack_pattern;
    int          ack_count;

    vecs.push_back('{3'd0, 1'b1, 4'h5, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h00A500A5, 8'hA5, 32'h0});
    vecs.push_back('{3'd0, 1'b0, 4'h0, 32'h0, 32'h00A500A5, 32'h000000A5, 32'h00A500A5, 8'hA5, 32'h0});
    vecs.push_back('{3'd0, 1'b1, 4'hF, 32'h0000FF00, 32'h0, 32'h0, 32'h0000FF00, 8'h00, 32'h0});
    vecs.push_back('{3'd3, 1'b1, 4'hF, 32'h000000F0, 32'h0, 32'h0, 32'h0000FFF0, 8'hF0, 32'h0});
    vecs.push_back('{3'd4, 1'b1, 4'hF, 32'h00000F00, 32'h0, 32'h0, 32'h0000F0F0, 8'hF0, 32'h0});
    vecs.push_back('{3'd3, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0000F0F0, 8'hF0, 32'h0});
    vecs.push_back('{3'd4, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0000F0F0, 8'hF0, 32'h0});
    vecs.push_back('{3'd2, 1'b1, 4'hE, 32'hFFFF00FF, 32'h0, 32'h0, 32'h0000F0F0, 8'hF0, 32'hFFFF0000});
    vecs.push_back('{3'd2, 1'b0, 4'h0, 32'h0, 32'hFFFF0000, 32'h0, 32'h0000F0F0, 8'hF0, 32'hFFFF0000});
    vecs.push_back('{3'd3, 1'b1, 4'h2, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0000FFF0, 8'hF0, 32'hFFFF0000});
    vecs.push_back('{3'd4, 1'b1, 4'h1, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0000FF00, 8'h00, 32'hFFFF0000});
    vecs.push_back('{3'd1, 1'b1, 4'hF, 32'h12345678, 32'h0, 32'h0, 32'h0000FF00, 8'h00, 32'hFFFF0000});
    vecs.push_back('{3'd1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0000FF00, 8'h00, 32'hFFFF0000});
    vecs.push_back('{3'd5, 1'b1, 4'hF, 32'hABCDEF01, 32'h0, 32'h0, 32'h0000FF00, 8'h00, 32'hFFFF0000});
    vecs.push_back('{3'd5, 1'b0, 4'h0, 32'h0, 32'hABCDEF01, 32'h00000001, 32'h0000FF00, 8'h00, 32'hFFFF0000});
    vecs.push_back('{3'd6, 1'b1, 4'hF, 32'h12345602, 32'h0, 32'h0, 32'h0000FF00, 8'h00, 32'hFFFF0000});
    vecs.push_back('{3'd6, 1'b0, 4'h0, 32'h0, 32'h12345602, 32'h00000002, 32'h0000FF00, 8'h00, 32'hFFFF0000});
    vecs.push_back('{3'd7, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0000FF00, 8'h00, 32'hFFFF0000});
    vecs.push_back('{3'd5, 1'b1, 4'hF, 32'h0, 32'h0, 32'h0, 32'h0000FF00, 8'h00, 32'hFFFF0000});
    vecs.push_back('{3'd6, 1'b1, 4'hF, 32'h0, 32'h0, 32'h0, 32'h0000FF00, 8'h00, 32'hFFFF0000});
    vecs.push_back('{3'd0, 1'b0, 4'h0, 32'h0, 32'h0000FF00, 32'h0, 32'h0000FF00, 8'h00, 32'hFFFF0000});

    rst_n = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat = '0;
    gpio_in = 32'hFFFFFFFF;
    waitCycles(2);
    checkOutput("rst_gpio_o", out32, 32'h0);
    checkOutput("rst_gpio_oe", oe32, 32'h0);
    checkOutput("rst_irq", {31'b0, irq32}, 32'h0);
    checkOutput("rst_ack", {31'b0, ack32}, 32'h0);
    checkOutput("rst_gpio_o8", {24'b0, out8}, 32'h0);
    checkOutput("rst_irq8", {31'b0, irq8}, 32'h0);
    rst_n = 1'b1;
    applyStimulus(3'd7, 1'b0, 4'h0, 32'h0, rd32, rd8);
    checkOutput("rst_stat_read", rd32, 32'h0);
    gpio_in = 32'h0;
    waitCycles(4);

    // Held strobe: acks must alternate, two in four cycles.
    adr = 3'd0; we = 1'b0; sel = 4'h0; stb = 1'b1;
    ack_count = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ack_pattern[i] = ack32;
      if (ack32) ack_count++;
    end
    stb = 1'b0;
    checkOutput("held_stb_ack_count", ack_count, 32'd2);
    checkOutput("held_stb_ack_pattern", {28'b0, ack_pattern}, 32'h5);
    waitCycles(1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].adr, vecs[i].we, vecs[i].sel, vecs[i].dat, rd32, rd8);
      if (!vecs[i].we) begin
        checkOutput($sformatf("vec%0d_rd32", i), rd32, vecs[i].exp_rd32);
        checkOutput($sformatf("vec%0d_rd8", i), rd8, vecs[i].exp_rd8);
      end
      checkOutput($sformatf("vec%0d_out32", i), out32, vecs[i].exp_out32);
      checkOutput($sformatf("vec%0d_out8", i), {24'b0, out8}, {24'b0, vecs[i].exp_out8});
      checkOutput($sformatf("vec%0d_oe32", i), oe32, vecs[i].exp_oe32);
    end

    // Pins set before edge k must be readable by a read accepted at edge k+2.
    gpio_in = 32'hFFFFFF3C;
    waitCycles(1);
    waitCycles(1);
    applyStimulus(3'd1, 1'b0, 4'h0, 32'h0, rd32, rd8);
    checkOutput("in_read32", rd32, 32'hFFFFFF3C);
    checkOutput("in_read8", rd8, 32'h0000003C);
    gpio_in = 32'h0;
    waitCycles(4);

    applyStimulus(3'd5, 1'b1, 4'hF, 32'h1, rd32, rd8);
    applyStimulus(3'd6, 1'b1, 4'hF, 32'h2, rd32, rd8);
    gpio_in = 32'h2;
    waitCycles(4);
    applyStimulus(3'd7, 1'b0, 4'h0, 32'h0, rd32, rd8);
    checkOutput("rise_bit1_stat", rd32, 32'h0);
    checkOutput("rise_bit1_irq", {31'b0, irq32}, 32'h0);

    gpio_in = 32'h3;
    waitCycles(1);
    waitCycles(1);
    checkOutput("rise0_irq_early", {31'b0, irq32}, 32'h0);
    waitCycles(1);
    checkOutput("rise0_irq", {31'b0, irq32}, 32'h1);
    checkOutput("rise0_irq8", {31'b0, irq8}, 32'h1);
    waitCycles(3);
    gpio_in = 32'h2;
    waitCycles(4);
    applyStimulus(3'd7, 1'b0, 4'h0, 32'h0, rd32, rd8);
    checkOutput("stat_after_pulse", rd32, 32'h1);
    gpio_in = 32'h0;
    waitCycles(4);
    applyStimulus(3'd7, 1'b0, 4'h0, 32'h0, rd32, rd8);
    checkOutput("stat_after_fall32", rd32, 32'h3);
    checkOutput("stat_after_fall8", rd8, 32'h3);
    checkOutput("irq_after_fall", {31'b0, irq32}, 32'h1);

    applyStimulus(3'd7, 1'b1, 4'hF, 32'h3, rd32, rd8);
    checkOutput("w1c_all_irq", {31'b0, irq32}, 32'h0);
    gpio_in = 32'h1;
    waitCycles(4);
    gpio_in = 32'h0;
    waitCycles(4);
    checkOutput("stat01_irq", {31'b0, irq32}, 32'h1);

    // Rising edge reaches STAT on the same edge that accepts the W1C.
    gpio_in = 32'h1;
    waitCycles(1);
    waitCycles(1);
    applyStimulus(3'd7, 1'b1, 4'hF, 32'h1, rd32, rd8);
    checkOutput("race_irq", {31'b0, irq32}, 32'h1);
    checkOutput("race_irq8", {31'b0, irq8}, 32'h1);
    applyStimulus(3'd7, 1'b0, 4'h0, 32'h0, rd32, rd8);
    checkOutput("race_stat", rd32, 32'h1);

    applyStimulus(3'd7, 1'b1, 4'hE, 32'hFFFFFFFF, rd32, rd8);
    applyStimulus(3'd7, 1'b0, 4'h0, 32'h0, rd32, rd8);
    checkOutput("w1c_unselected", rd32, 32'h1);

    applyStimulus(3'd7, 1'b1, 4'hF, 32'h1, rd32, rd8);
    checkOutput("w1c_irq", {31'b0, irq32}, 32'h0);
    checkOutput("w1c_irq8", {31'b0, irq8}, 32'h0);
    applyStimulus(3'd7, 1'b0, 4'h0, 32'h0, rd32, rd8);
    checkOutput("w1c_stat", rd32, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
